// File: rtl/csr_file_pkg.sv
// Shared CSR types and constants: request encoding from decode, CSR addresses,
// mstatus bit positions and architectural mcause codes.
package csr_file_pkg;

  typedef enum logic [1:0] {
    CSR_WF_NONE = 2'b00,
    CSR_WF_RW   = 2'b01,
    CSR_WF_RS   = 2'b10,
    CSR_WF_RC   = 2'b11
  } csr_write_func;

  typedef enum logic {
    CSR_SEL_REG = 1'b0,
    CSR_SEL_IMM = 1'b1
  } csr_input_sel;

  typedef struct packed {
    logic          read_enable;
    logic          write_enable;
    csr_input_sel  input_select;
    csr_write_func write_func;
  } csr_params_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [31:0] {
    MCAUSE_ILLEGAL_INSTR = 32'h0000_0002,
    MCAUSE_BREAKPOINT    = 32'h0000_0003,
    MCAUSE_ECALL_M       = 32'h0000_000B,
    MCAUSE_M_SW_IRQ      = 32'h8000_0003,
    MCAUSE_M_TIMER_IRQ   = 32'h8000_0007,
    MCAUSE_M_EXT_IRQ     = 32'h8000_000B
  } mcause_e;

endpackage

// File: rtl/csr_file_if.sv
// CSR request/response bus between writeback decode (master) and csr_file (slave).
interface csr_file_if #(parameter int XLEN = 32) ();
  import csr_file_pkg::*;

  logic            req_valid;
  csr_params_t     csr_params;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] rs1_value;
  logic [4:0]      uimm;
  logic            rd_valid;
  logic [XLEN-1:0] rd_data;
  logic            illegal;

  modport master (
    output req_valid, csr_params, csr_addr, rs1_value, uimm,
    input  rd_valid, rd_data, illegal
  );

  modport slave (
    input  req_valid, csr_params, csr_addr, rs1_value, uimm,
    output rd_valid, rd_data, illegal
  );
endinterface

// File: rtl/csr_file_counter64.sv
// 64-bit counter with independent half writes; a write to either half
// suppresses that cycle's increment, otherwise carry runs straight through.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);
  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo)      cnt_d[31:0]  = wdata;
    else if (wr_hi) cnt_d[63:32] = wdata;
    else if (inc)   cnt_d        = cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: decode, read-modify-write, trap/MRET state and counters.
// Responses are registered one cycle after the request.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MHARTID_VAL = 32'h0,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            rst,
  csr_file_if.slave       bus,
  input  logic            retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_valid,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic            mie_global
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic            rd_valid_q, illegal_q;
  logic [XLEN-1:0] rd_data_q;
  logic [63:0]     mcycle, minstret;

  logic [XLEN-1:0] mstatus_val, old_val, op, new_val;
  logic            implemented, read_only, fault, wr_en, rd_en;

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie_q;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Single decode point: read value, whether the address exists, whether it is writable.
  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    read_only   = (bus.csr_addr[11:10] == 2'b11);
    case (bus.csr_addr)
      CSR_MSTATUS:                 old_val = mstatus_val;
      CSR_MISA:                    old_val = MISA_VAL;
      CSR_MIE:                     old_val = mie_q;
      CSR_MTVEC:                   old_val = mtvec_q;
      CSR_MSCRATCH:                old_val = mscratch_q;
      CSR_MEPC:                    old_val = mepc_q;
      CSR_MCAUSE:                  old_val = mcause_q;
      CSR_MCYCLE, CSR_CYCLE:       old_val = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     old_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   old_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
      CSR_MHARTID:                 old_val = MHARTID_VAL;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: old_val = '0;
      default:                     implemented = 1'b0;
    endcase
  end

  always_comb begin
    op = (bus.csr_params.input_select == CSR_SEL_REG) ? bus.rs1_value
                                                      : {{(XLEN-5){1'b0}}, bus.uimm};
    case (bus.csr_params.write_func)
      CSR_WF_RW: new_val = op;
      CSR_WF_RS: new_val = old_val | op;
      CSR_WF_RC: new_val = old_val & ~op;
      default:   new_val = old_val;
    endcase
  end

  // A trap silently swallows a concurrent write; it is not reported as illegal.
  assign fault = bus.req_valid & (~implemented | (bus.csr_params.write_enable & read_only));
  assign wr_en = bus.req_valid & bus.csr_params.write_enable & ~fault & ~trap_valid;
  assign rd_en = bus.req_valid & bus.csr_params.read_enable & ~fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      illegal_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_en ? old_val : '0;
      illegal_q  <= fault;
      if (trap_valid) begin
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_valid) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (wr_en && bus.csr_addr == CSR_MSTATUS) begin
        mstatus_mie_q  <= new_val[MSTATUS_MIE];
        mstatus_mpie_q <= new_val[MSTATUS_MPIE];
      end
      if (trap_valid) begin
        mepc_q   <= trap_pc & ALIGN_MASK;
        mcause_q <= trap_cause;
      end else if (wr_en) begin
        if (bus.csr_addr == CSR_MEPC)   mepc_q   <= new_val & ALIGN_MASK;
        if (bus.csr_addr == CSR_MCAUSE) mcause_q <= new_val;
      end
      if (wr_en && bus.csr_addr == CSR_MIE)      mie_q      <= new_val;
      if (wr_en && bus.csr_addr == CSR_MTVEC)    mtvec_q    <= new_val & ALIGN_MASK;
      if (wr_en && bus.csr_addr == CSR_MSCRATCH) mscratch_q <= new_val;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_en && bus.csr_addr == CSR_MCYCLE),
    .wr_hi (wr_en && bus.csr_addr == CSR_MCYCLEH),
    .wdata (new_val),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .wr_lo (wr_en && bus.csr_addr == CSR_MINSTRET),
    .wr_hi (wr_en && bus.csr_addr == CSR_MINSTRETH),
    .wdata (new_val),
    .value (minstret)
  );

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.illegal  = illegal_q;
  assign mtvec_out    = mtvec_q;
  assign mepc_out     = mepc_q;
  assign mie_global   = mstatus_mie_q;
endmodule
